// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave holding a bank of software-writable control registers for user
// logic. Writes land in shadow registers; with double buffering enabled they
// reach the user outputs only when a COMMIT write names them, so multi-word
// settings change atomically. User logic shares the OPB clock.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR      = 32'h01000E00,
    parameter logic [31:0] C_HIGHADDR      = 32'h01000EFF,
    parameter int          C_OPB_AWIDTH    = 32,
    parameter int          C_OPB_DWIDTH    = 32,
    parameter int          C_NUM_REGS      = 8,
    parameter int          C_REG_WIDTH     = 32,
    parameter logic [31:0] C_RESET_VALUE   = 32'h0,
    parameter int          C_DOUBLE_BUFFER = 1
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    input  logic [0:31]                       OPB_ABus,
    input  logic [0:3]                        OPB_BE,
    input  logic [0:31]                       OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:31]                       Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_update
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    localparam logic [C_REG_WIDTH-1:0] RST_V       = C_RESET_VALUE[C_REG_WIDTH-1:0];
    localparam logic [29:0]            WORD_COMMIT = 30'd32;  // offset 0x80
    localparam logic [29:0]            WORD_STATUS = 30'd33;  // offset 0x84

    state_t state_q, state_d;

    logic [31:0] abus;
    logic [31:0] dbus;
    logic [3:0]  be_v;      // be_v[k] enables value bits 8k+7:8k
    logic [31:0] lane_mask;
    logic [31:0] offset;
    logic        hit;
    logic [31:0] rd_word;

    logic [31:0] rdata_q, rdata_d;
    logic        op_wr_q, op_wr_d;
    logic [29:0] op_word_q, op_word_d;
    logic [31:0] op_mask_q, op_mask_d;
    logic [31:0] op_data_q, op_data_d;
    logic [31:0] commit_bits;
    logic [31:0] wr_word;

    logic [C_NUM_REGS-1:0][C_REG_WIDTH-1:0] shadow_q, shadow_d;
    logic [C_NUM_REGS-1:0][C_REG_WIDTH-1:0] active_q, active_d;
    logic [C_NUM_REGS-1:0]                  pending_q, pending_d;
    logic [C_NUM_REGS-1:0]                  update_q, update_d;
    logic [15:0]                            count_q, count_d;

    logic unused_ok;

    // OPB numbers bits MSB-first; the vectors below use value bit numbering.
    assign abus      = OPB_ABus;
    assign dbus      = OPB_DBus;
    assign be_v      = {OPB_BE[0], OPB_BE[1], OPB_BE[2], OPB_BE[3]};
    assign lane_mask = {{8{be_v[3]}}, {8{be_v[2]}}, {8{be_v[1]}}, {8{be_v[0]}}};
    assign offset    = abus - C_BASEADDR;
    assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    assign commit_bits = op_data_q & op_mask_q;

    assign Sl_DBus       = rdata_q;
    assign Sl_xferAck    = (state_q == S_ACK);
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = active_q;
    assign user_update   = update_q;

    assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0], wr_word,
                         1'(C_OPB_AWIDTH), 1'(C_OPB_DWIDTH)};

    // Read mux: shadow registers, pending mask and commit count by word offset.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (offset[31:2] == 30'(i)) begin
                rd_word = 32'(shadow_q[i]);
            end
        end
        if (offset[31:2] == WORD_COMMIT) begin
            rd_word = 32'(pending_q);
        end
        if (offset[31:2] == WORD_STATUS) begin
            rd_word = {16'h0000, count_q};
        end
    end

    // Slave FSM plus capture of the operation on the hit edge.
    always_comb begin
        state_d   = state_q;
        rdata_d   = '0;
        op_wr_d   = 1'b0;
        op_word_d = op_word_q;
        op_mask_d = op_mask_q;
        op_data_d = op_data_q;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d   = S_ACK;
                    rdata_d   = OPB_RNW ? rd_word : 32'h0;
                    op_wr_d   = !OPB_RNW;
                    op_word_d = offset[31:2];
                    op_mask_d = lane_mask;
                    op_data_d = dbus;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register bank update: shadow write or commit, executed at the end of ACK.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        update_d  = '0;
        count_d   = count_q;
        wr_word   = '0;
        if (state_q == S_ACK && op_wr_q) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (op_word_q == 30'(i)) begin
                    wr_word     = (32'(shadow_q[i]) & ~op_mask_q) | (op_data_q & op_mask_q);
                    shadow_d[i] = wr_word[C_REG_WIDTH-1:0];
                    if (C_DOUBLE_BUFFER != 0) begin
                        pending_d[i] = 1'b1;
                    end else begin
                        active_d[i] = wr_word[C_REG_WIDTH-1:0];
                        update_d[i] = 1'b1;
                    end
                end
            end
            if (op_word_q == WORD_COMMIT) begin
                count_d = count_q + 16'd1;
                if (C_DOUBLE_BUFFER != 0) begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        if (commit_bits[i]) begin
                            active_d[i]  = shadow_q[i];
                            pending_d[i] = 1'b0;
                            update_d[i]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Control and register state, cleared asynchronously.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q   <= S_IDLE;
            rdata_q   <= '0;
            op_wr_q   <= 1'b0;
            shadow_q  <= {C_NUM_REGS{RST_V}};
            active_q  <= {C_NUM_REGS{RST_V}};
            pending_q <= '0;
            update_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            op_wr_q   <= op_wr_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            update_q  <= update_d;
            count_q   <= count_d;
        end
    end

    // Captured address/lanes/data; only meaningful while op_wr_q is set.
    always_ff @(posedge OPB_Clk) begin
        op_word_q <= op_word_d;
        op_mask_q <= op_mask_d;
        op_data_q <= op_data_d;
    end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: a default double-buffered
// instance and a 12-bit direct-write instance share one bus.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01000E00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] opb_abus = '0;
    logic [0:3]  opb_be = '0;
    logic [0:31] opb_dbus = '0;
    logic        opb_rnw = 1'b1;
    logic        opb_sel = 1'b0;
    logic        opb_seq = 1'b0;

    logic [0:31]  dbus1, dbus2;
    logic         ack1, ack2, err1, err2, rty1, rty2, tout1, tout2;
    logic [255:0] udo1;
    logic [7:0]   upd1;
    logic [95:0]  udo2;
    logic [7:0]   upd2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink u_dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
        .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_sel),
        .OPB_seqAddr(opb_seq), .Sl_DBus(dbus1), .Sl_xferAck(ack1),
        .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tout1),
        .user_data_out(udo1), .user_update(upd1)
    );

    opb_register_bank_ppc2simulink #(.C_REG_WIDTH(12), .C_DOUBLE_BUFFER(0)) u_dut12 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(opb_abus), .OPB_BE(opb_be),
        .OPB_DBus(opb_dbus), .OPB_RNW(opb_rnw), .OPB_select(opb_sel),
        .OPB_seqAddr(opb_seq), .Sl_DBus(dbus2), .Sl_xferAck(ack2),
        .Sl_errAck(err2), .Sl_retry(rty2), .Sl_toutSup(tout2),
        .user_data_out(udo2), .user_update(upd2)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; returns at the cycle after the ack (HOLD state).
    // lat = cycles from the select edge to the ack, 0 if no ack within 6 cycles.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                        input logic [31:0] data, output logic [31:0] rd1,
                        output logic [31:0] rd2, output int lat);
        logic done;
        @(posedge clk); #1;
        opb_abus = addr; opb_rnw = rnw; opb_be = be; opb_dbus = data; opb_sel = 1'b1;
        lat = 0; rd1 = '0; rd2 = '0; done = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (!done) begin
                @(posedge clk); #1;
                if (ack1) begin
                    lat = k; rd1 = dbus1; rd2 = dbus2; done = 1'b1;
                end
            end
        end
        opb_sel = 1'b0; opb_rnw = 1'b1; opb_be = '0; opb_dbus = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r1, r2;
        int lat, acks, first, second;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_udo", udo1, 256'h0);
        check("rst_ack", ack1, 1'b0);
        check("rst_dbus", dbus1, 32'h0);
        check("rst_upd", upd1, 8'h0);
        check("tied_outs", {err1, rty1, tout1}, 3'b000);
        rst = 1'b0;

        // STATUS read after reset, ack one cycle after select
        xfer(BASE + 32'h84, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("status_rst", r1, 32'h0);
        check("ack_latency", lat, 1);

        // Full write to reg1: shadow only, active untouched
        xfer(BASE + 32'h04, 1'b0, 4'hF, 32'hDEADBEEF, r1, r2, lat);
        check("wr_no_upd", upd1, 8'h00);
        check("wr_active_same", udo1[63:32], 32'h0);
        check("dut12_upd", upd2, 8'h02);
        check("dut12_direct", udo2[23:12], 12'hEEF);
        xfer(BASE + 32'h04, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("rd_reg1", r1, 32'hDEADBEEF);
        xfer(BASE + 32'h80, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("pending_02", r1, 32'h2);

        // Commit reg1
        xfer(BASE + 32'h80, 1'b0, 4'hF, 32'h2, r1, r2, lat);
        check("commit_active", udo1[63:32], 32'hDEADBEEF);
        check("commit_upd", upd1, 8'h02);
        @(posedge clk); #1;
        check("commit_upd_off", upd1, 8'h00);
        xfer(BASE + 32'h80, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("pending_clr", r1, 32'h0);
        xfer(BASE + 32'h84, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("count_1", r1, 32'h1);

        // Byte-lane write: BE=0100 hits value bits 23:16
        xfer(BASE + 32'h0C, 1'b0, 4'b0100, 32'h11223344, r1, r2, lat);
        xfer(BASE + 32'h0C, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("be_lane", r1, 32'h00220000);

        // 12-bit instance truncates
        xfer(BASE + 32'h08, 1'b0, 4'hF, 32'hFFFFFFFF, r1, r2, lat);
        check("dut12_upd_r2", upd2, 8'h04);
        check("dut12_active", udo2[35:24], 12'hFFF);
        xfer(BASE + 32'h08, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("dut12_rd", r2, 32'h00000FFF);
        check("rd_reg2", r1, 32'hFFFFFFFF);
        xfer(BASE + 32'h80, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("dut12_pending0", r2, 32'h0);

        // Select held for 6 cycles: two acks at cycles 1 and 4
        @(posedge clk); #1;
        opb_abus = BASE; opb_rnw = 1'b1; opb_be = 4'hF; opb_sel = 1'b1;
        acks = 0; first = 0; second = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (ack1) begin
                acks++;
                if (first == 0) first = k;
                else second = k;
            end
        end
        opb_sel = 1'b0;
        @(posedge clk); #1;
        check("hold_acks", acks, 2);
        check("hold_first", first, 1);
        check("hold_second", second, 4);

        // Outside window: no ack; unmapped offset: ack with zero data
        xfer(32'h01000F00, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("out_of_window", lat, 0);
        xfer(BASE + 32'h40, 1'b0, 4'hF, 32'hCAFEF00D, r1, r2, lat);
        check("unmapped_wr_ack", lat, 1);
        xfer(BASE + 32'h40, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("unmapped_ack", lat, 1);
        check("unmapped_data", r1, 32'h0);

        // Reset asserted during the ACK of a write
        @(posedge clk); #1;
        opb_abus = BASE + 32'h14; opb_rnw = 1'b0; opb_be = 4'hF;
        opb_dbus = 32'h12345678; opb_sel = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", ack1, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_ack_drop", ack1, 1'b0);
        opb_sel = 1'b0; opb_rnw = 1'b1; opb_be = '0; opb_dbus = '0;
        @(posedge clk); #1;
        check("rst_udo_clear", udo1, 256'h0);
        rst = 1'b0;
        xfer(BASE + 32'h14, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("rst_dropped_wr", r1, 32'h0);
        xfer(BASE + 32'h04, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("rst_shadow", r1, 32'h0);
        xfer(BASE + 32'h84, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("rst_count", r1, 32'h0);

        // Commit lane masking, zero masks and out-of-range mask bits
        xfer(BASE + 32'h00, 1'b0, 4'hF, 32'h000000A5, r1, r2, lat);
        xfer(BASE + 32'h08, 1'b0, 4'hF, 32'h0000005A, r1, r2, lat);
        xfer(BASE + 32'h80, 1'b0, 4'b1110, 32'h00000005, r1, r2, lat);
        check("masked_commit_upd", upd1, 8'h00);
        check("masked_commit_udo", udo1, 256'h0);
        xfer(BASE + 32'h80, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("pending_05", r1, 32'h5);
        xfer(BASE + 32'h80, 1'b0, 4'b0001, 32'h00000005, r1, r2, lat);
        check("commit05_upd", upd1, 8'h05);
        check("commit05_r0", udo1[31:0], 32'hA5);
        check("commit05_r2", udo1[95:64], 32'h5A);
        xfer(BASE + 32'h80, 1'b0, 4'hF, 32'hFFFFFF00, r1, r2, lat);
        check("hi_mask_upd", upd1, 8'h00);
        xfer(BASE + 32'h84, 1'b1, 4'hF, 32'h0, r1, r2, lat);
        check("count_3", r1, 32'h3);
        check("dut12_count_3", r2, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
OPB slave exposing a bank of C_NUM_REGS software-writable control registers to Simulink user logic, replacing one-register-per-core instances. Supports byte-enable writes, readback, and optional double buffering: writes land in shadow registers and reach user outputs only on an atomic commit. This keeps multi-word settings such as FIR coefficient sets coherent. Single clock domain: user logic runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01000E00, first byte address of the slave window
C_HIGHADDR, 32'h01000EFF, last byte address of the window; span must be >= 0x88
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported
C_NUM_REGS, 8, number of user registers, 1..32
C_REG_WIDTH, 32, bits per register, 1..32
C_RESET_VALUE, 0, reset value of every shadow and active register, truncated to C_REG_WIDTH
C_DOUBLE_BUFFER, 1, 1 = shadow plus commit; 0 = writes go directly to outputs

Ports:
OPB_Clk  in  1  sole clock for bus and user sides
OPB_Rst  in  1  asynchronous, active-high reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7], which is value bits 31:24
OPB_DBus  in  [0:31]  write data; bit 0 is the MSB
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transaction valid
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  [C_NUM_REGS*C_REG_WIDTH-1:0]  active registers; reg i occupies bits [i*C_REG_WIDTH +: C_REG_WIDTH]
user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse per register whose active value was loaded

Behaviour:
- Address map, offsets from C_BASEADDR:
  - 4*i: reg i shadow, read/write, for i < C_NUM_REGS.
  - 0x80 COMMIT: write = commit mask; read = pending mask.
  - 0x84 STATUS: read-only; bits 15:0 = commit count.
- Other offsets inside the window are unmapped: reads return 0, writes are ignored, and the transaction is still acked.
- Addresses outside the window get no response; Sl_xferAck stays 0.
- Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Address bits [1:0] are ignored.
- Slave FSM has three states, IDLE, ACK and HOLD:
  - IDLE -> ACK on a hit sampled at clock edge t.
  - ACK drives Sl_xferAck=1 for exactly one cycle (cycle t+1) and latches the operation at the end of that cycle. ACK -> HOLD.
  - HOLD -> IDLE unconditionally. HOLD exists so a lingering select is not re-acked.
  - Throughput is one transaction per 3 cycles.
- Sl_DBus carries read data only during ACK with RNW=1; it is 0 otherwise. Read data is registered at edge t.
- Register reads return the shadow value, zero-extended to 32 bits.
- Writes:
  - Each byte lane with BE set is updated; other lanes keep their value.
  - Bits at or above C_REG_WIDTH are discarded.
  - A write to reg i sets pending[i].
- C_DOUBLE_BUFFER=1:
  - Writing mask M to COMMIT copies shadow to active for every i with M[i]=1 and i < C_NUM_REGS, regardless of pending state.
  - pending[i] is cleared for each committed register.
  - user_update[i] pulses in the cycle after active changes.
  - Commit count increments by 1 per COMMIT write, including M=0, and wraps at 0xFFFF -> 0.
  - COMMIT writes honour only byte lanes whose BE is set; masked lanes contribute 0.
- C_DOUBLE_BUFFER=0:
  - Shadow and active are the same register; user_update[i] pulses the cycle after the write is latched.
  - COMMIT writes only increment the count; pending reads as 0.
- Only one bus operation is latched per transaction, so shadow write and commit never coincide.
- Async reset, including mid-transaction:
  - FSM goes to IDLE immediately; Sl_xferAck=0 and Sl_DBus=0.
  - Shadow and active registers take C_RESET_VALUE.
  - pending, user_update and the commit count go to 0.
  - An in-flight transaction is dropped, unacked.

Test Plan:
- Reset with defaults -> user_data_out all 0, Sl_xferAck=0; read of 0x01000E84 returns 0 with ack exactly 1 cycle after select.
- Write 0xDEADBEEF to 0x01000E04 with BE=1111 -> read returns 0xDEADBEEF, pending=0x02, user_data_out[63:32] unchanged, no user_update pulse.
- Write 0x00000002 to COMMIT -> user_data_out[63:32]=0xDEADBEEF one cycle after ack, user_update=0x02 for one cycle, pending=0, count=1.
- Write 0x11223344 with BE=0100 to reg 3, whose value is 0 -> reads 0x00220000. With C_REG_WIDTH=12, a full write of 0xFFFFFFFF reads 0x00000FFF.
- Hold OPB_select high for 6 cycles on a single read -> exactly two acks, at cycles t+1 and t+4. An address of 0x01000F00 -> no ack. Offset 0x40 -> ack, data 0.
- Assert OPB_Rst during ACK of a write -> ack drops the same cycle and the register stays at C_RESET_VALUE. 65536 COMMIT writes -> count wraps to 0.
